// File: rtl/data_synchronizer_pkg.sv
// Shared types and limits for the multi-channel data synchronizer.
package data_synchronizer_pkg;

  localparam int MIN_STAGE_COUNT = 2;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_DROP = 1'b1
  } channel_state_t;

endpackage

// File: rtl/data_synchronizer_channel.sv
// One channel: valid synchronizer, rising-edge pulse, capture FSM and four-phase ack.
// Optional checker enabled by DATA_SYNCHRONIZER_PROTOCOL_CHECK_EN.
module data_synchronizer_channel
  import data_synchronizer_pkg::*;
#(
  parameter int STAGE_COUNT = 2,
  parameter int BUS_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 asynchronous_data_valid,
  input  logic [BUS_WIDTH-1:0] asynchronous_data,
  output logic [BUS_WIDTH-1:0] synchronous_data,
  output logic                 synchronous_data_valid,
  output logic                 Q_pulse_generator,
  output logic                 asynchronous_data_ack
`ifdef DATA_SYNCHRONIZER_PROTOCOL_CHECK_EN
  ,
  output logic                 protocol_error
`endif
);

  channel_state_t         state, state_next;
  logic [STAGE_COUNT-1:0] sync_q;
  logic                   sync_out;
  logic                   pulse;
  logic [BUS_WIDTH-1:0]   data_next;
  logic                   valid_next;
  logic                   ack_next;

  assign sync_out = sync_q[STAGE_COUNT-1];
  assign pulse    = sync_out & ~Q_pulse_generator;

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_next = state;
    data_next  = synchronous_data;
    valid_next = 1'b0;
    ack_next   = asynchronous_data_ack;
    case (state)
      IDLE: begin
        if (pulse) begin
          data_next  = asynchronous_data;
          valid_next = 1'b1;
          ack_next   = 1'b1;
          state_next = WAIT_DROP;
        end
      end
      WAIT_DROP: begin
        if (!sync_out) begin
          ack_next   = 1'b0;
          state_next = IDLE;
        end
      end
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q                 <= '0;
      Q_pulse_generator      <= 1'b0;
      state                  <= IDLE;
      synchronous_data       <= '0;
      synchronous_data_valid <= 1'b0;
      asynchronous_data_ack  <= 1'b0;
    end else begin
      sync_q                 <= {sync_q[STAGE_COUNT-2:0], asynchronous_data_valid};
      Q_pulse_generator      <= sync_out;
      state                  <= state_next;
      synchronous_data       <= data_next;
      synchronous_data_valid <= valid_next;
      asynchronous_data_ack  <= ack_next;
    end
  end

`ifdef DATA_SYNCHRONIZER_PROTOCOL_CHECK_EN
  // Source data must stay put while the handshake is open; two hits in a row filter metastable reads.
  logic mismatch;
  logic mismatch_q;

  assign mismatch = (state == WAIT_DROP) && sync_out && (asynchronous_data != synchronous_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch_q     <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      mismatch_q <= mismatch;
      if (mismatch && mismatch_q) protocol_error <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/multi_channel_data_synchronizer.sv
// CHANNEL_COUNT independent valid/data synchronizers with four-phase acknowledge.
// Optional protocol_error output enabled by DATA_SYNCHRONIZER_PROTOCOL_CHECK_EN.
module multi_channel_data_synchronizer
  import data_synchronizer_pkg::*;
#(
  parameter int STAGE_COUNT   = 2,
  parameter int BUS_WIDTH     = 8,
  parameter int CHANNEL_COUNT = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [CHANNEL_COUNT-1:0]           asynchronous_data_valid,
  input  logic [CHANNEL_COUNT*BUS_WIDTH-1:0] asynchronous_data,
  output logic [CHANNEL_COUNT*BUS_WIDTH-1:0] synchronous_data,
  output logic [CHANNEL_COUNT-1:0]           synchronous_data_valid,
  output logic [CHANNEL_COUNT-1:0]           Q_pulse_generator,
  output logic [CHANNEL_COUNT-1:0]           asynchronous_data_ack
`ifdef DATA_SYNCHRONIZER_PROTOCOL_CHECK_EN
  ,
  output logic [CHANNEL_COUNT-1:0]           protocol_error
`endif
);

  if (STAGE_COUNT < MIN_STAGE_COUNT) begin : g_bad_stage_count
    $error("STAGE_COUNT must be at least %0d", MIN_STAGE_COUNT);
  end
  if (CHANNEL_COUNT < 1) begin : g_bad_channel_count
    $error("CHANNEL_COUNT must be at least 1");
  end

  for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_channel
    data_synchronizer_channel #(
      .STAGE_COUNT(STAGE_COUNT),
      .BUS_WIDTH  (BUS_WIDTH)
    ) u_channel (
      .clk                    (clk),
      .reset                  (reset),
      .asynchronous_data_valid(asynchronous_data_valid[c]),
      .asynchronous_data      (asynchronous_data[c*BUS_WIDTH +: BUS_WIDTH]),
      .synchronous_data       (synchronous_data[c*BUS_WIDTH +: BUS_WIDTH]),
      .synchronous_data_valid (synchronous_data_valid[c]),
      .Q_pulse_generator      (Q_pulse_generator[c]),
      .asynchronous_data_ack  (asynchronous_data_ack[c])
`ifdef DATA_SYNCHRONIZER_PROTOCOL_CHECK_EN
      ,
      .protocol_error         (protocol_error[c])
`endif
    );
  end

endmodule

// File: tb/tb_multi_channel_data_synchronizer.sv
// Bench for multi_channel_data_synchronizer: vector table, corner sequences and random traffic
// against a timeline reference model. Protocol checker tested when DATA_SYNCHRONIZER_PROTOCOL_CHECK_EN is set.
module tb_multi_channel_data_synchronizer;

  localparam int STAGE_COUNT   = 2;
  localparam int BUS_WIDTH     = 8;
  localparam int CHANNEL_COUNT = 4;
  localparam int DW            = CHANNEL_COUNT * BUS_WIDTH;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [CHANNEL_COUNT-1:0] asynchronous_data_valid;
  logic [DW-1:0]            asynchronous_data;
  logic [DW-1:0]            synchronous_data;
  logic [CHANNEL_COUNT-1:0] synchronous_data_valid;
  logic [CHANNEL_COUNT-1:0] Q_pulse_generator;
  logic [CHANNEL_COUNT-1:0] asynchronous_data_ack;
`ifdef DATA_SYNCHRONIZER_PROTOCOL_CHECK_EN
  logic [CHANNEL_COUNT-1:0] protocol_error;
`endif

  multi_channel_data_synchronizer #(
    .STAGE_COUNT  (STAGE_COUNT),
    .BUS_WIDTH    (BUS_WIDTH),
    .CHANNEL_COUNT(CHANNEL_COUNT)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .asynchronous_data_valid(asynchronous_data_valid),
    .asynchronous_data      (asynchronous_data),
    .synchronous_data       (synchronous_data),
    .synchronous_data_valid (synchronous_data_valid),
    .Q_pulse_generator      (Q_pulse_generator),
    .asynchronous_data_ack  (asynchronous_data_ack)
`ifdef DATA_SYNCHRONIZER_PROTOCOL_CHECK_EN
    ,
    .protocol_error         (protocol_error)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: sync_out after n edges is the valid sampled STAGE_COUNT edges earlier.
  logic [CHANNEL_COUNT-1:0] valid_hist[$];
  logic [DW-1:0]            m_data;
  logic [CHANNEL_COUNT-1:0] m_strobe, m_ack, m_q;

  function automatic logic [CHANNEL_COUNT-1:0] sync_out_after(int n);
    if (n >= STAGE_COUNT) return valid_hist[n-STAGE_COUNT];
    return '0;
  endfunction

  task automatic apply(input logic r, input logic [CHANNEL_COUNT-1:0] v, input logic [DW-1:0] d);
    int n;
    logic [CHANNEL_COUNT-1:0] so_old, q_old;
    reset                   = r;
    asynchronous_data_valid = v;
    asynchronous_data       = d;
    @(posedge clk);
    if (r) begin
      valid_hist.delete();
      m_data = '0; m_strobe = '0; m_ack = '0; m_q = '0;
    end else begin
      n      = valid_hist.size();
      so_old = sync_out_after(n);
      q_old  = sync_out_after(n - 1);
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
        m_strobe[c] = 1'b0;
        if (!m_ack[c]) begin
          if (so_old[c] && !q_old[c]) begin
            m_data[c*BUS_WIDTH +: BUS_WIDTH] = d[c*BUS_WIDTH +: BUS_WIDTH];
            m_strobe[c] = 1'b1;
            m_ack[c]    = 1'b1;
          end
        end else if (!so_old[c]) begin
          m_ack[c] = 1'b0;
        end
      end
      m_q = so_old;
      valid_hist.push_back(v);
    end
    #1;
    check("model_data",  64'(synchronous_data),       64'(m_data));
    check("model_valid", 64'(synchronous_data_valid), 64'(m_strobe));
    check("model_ack",   64'(asynchronous_data_ack),  64'(m_ack));
    check("model_qpg",   64'(Q_pulse_generator),      64'(m_q));
  endtask

  typedef struct {
    logic                     rst;
    logic [CHANNEL_COUNT-1:0] v;
    logic [DW-1:0]            d;
    logic [CHANNEL_COUNT-1:0] exp_strobe;
    logic [CHANNEL_COUNT-1:0] exp_ack;
    logic [DW-1:0]            exp_data;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int strobes, idx;
    bit got;
    logic [DW-1:0] d;
    logic [CHANNEL_COUNT-1:0] v;

    // Single transfer on channel 0, then all four channels together with staggered drops.
    tbl[0]  = '{1'b1, 4'h0, 32'h00000000, 4'h0, 4'h0, 32'h00000000};
    tbl[1]  = '{1'b0, 4'h1, 32'h000000A5, 4'h0, 4'h0, 32'h00000000};
    tbl[2]  = '{1'b0, 4'h1, 32'h000000A5, 4'h0, 4'h0, 32'h00000000};
    tbl[3]  = '{1'b0, 4'h1, 32'h000000A5, 4'h1, 4'h1, 32'h000000A5};
    tbl[4]  = '{1'b0, 4'h1, 32'h000000A5, 4'h0, 4'h1, 32'h000000A5};
    tbl[5]  = '{1'b0, 4'h0, 32'h000000A5, 4'h0, 4'h1, 32'h000000A5};
    tbl[6]  = '{1'b0, 4'h0, 32'h000000A5, 4'h0, 4'h1, 32'h000000A5};
    tbl[7]  = '{1'b0, 4'h0, 32'h000000A5, 4'h0, 4'h0, 32'h000000A5};
    tbl[8]  = '{1'b0, 4'hF, 32'h44332211, 4'h0, 4'h0, 32'h000000A5};
    tbl[9]  = '{1'b0, 4'hF, 32'h44332211, 4'h0, 4'h0, 32'h000000A5};
    tbl[10] = '{1'b0, 4'hF, 32'h44332211, 4'hF, 4'hF, 32'h44332211};
    tbl[11] = '{1'b0, 4'hF, 32'h44332211, 4'h0, 4'hF, 32'h44332211};
    tbl[12] = '{1'b0, 4'hC, 32'h44332211, 4'h0, 4'hF, 32'h44332211};
    tbl[13] = '{1'b0, 4'hC, 32'h44332211, 4'h0, 4'hF, 32'h44332211};
    tbl[14] = '{1'b0, 4'hC, 32'h44332211, 4'h0, 4'hC, 32'h44332211};
    tbl[15] = '{1'b0, 4'h0, 32'h44332211, 4'h0, 4'hC, 32'h44332211};
    tbl[16] = '{1'b0, 4'h0, 32'h44332211, 4'h0, 4'hC, 32'h44332211};
    tbl[17] = '{1'b0, 4'h0, 32'h44332211, 4'h0, 4'h0, 32'h44332211};

    m_data = '0; m_strobe = '0; m_ack = '0; m_q = '0;
    reset = 1'b1; asynchronous_data_valid = '0; asynchronous_data = '0;

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].rst, tbl[i].v, tbl[i].d);
      check($sformatf("tbl%0d_strobe", i), 64'(synchronous_data_valid), 64'(tbl[i].exp_strobe));
      check($sformatf("tbl%0d_ack", i),    64'(asynchronous_data_ack),  64'(tbl[i].exp_ack));
      check($sformatf("tbl%0d_data", i),   64'(synchronous_data),       64'(tbl[i].exp_data));
    end

    // All 16 four-bit codes through channel 1, each a full four-phase handshake.
    strobes = 0;
    for (int code = 0; code < 16; code++) begin
      d = DW'(code) << BUS_WIDTH;
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
        apply(1'b0, 4'b0010, d);
        if (synchronous_data_valid[1]) begin
          strobes++;
          check("sweep_data", 64'(synchronous_data[15:8]), 64'(code));
        end
        if (asynchronous_data_ack[1]) got = 1'b1;
      end
      check("sweep_ack_rise", 64'(got), 64'd1);
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
        apply(1'b0, 4'b0000, d);
        if (synchronous_data_valid[1]) strobes++;
        if (!asynchronous_data_ack[1]) got = 1'b1;
      end
      check("sweep_ack_fall", 64'(got), 64'd1);
    end
    check("sweep_strobes", 64'(strobes), 64'd16);

    // Valid held for 20 cycles on channel 2: one strobe, ack held.
    strobes = 0;
    d = 32'h00770000;
    for (int i = 0; i < 20; i++) begin
      apply(1'b0, 4'b0100, d);
      if (synchronous_data_valid[2]) strobes++;
      if (i >= STAGE_COUNT) check("held_ack", 64'(asynchronous_data_ack[2]), 64'd1);
    end
    check("held_strobes", 64'(strobes), 64'd1);
    check("held_data", 64'(synchronous_data[23:16]), 64'h77);
    for (int i = 0; i < STAGE_COUNT + 1; i++) apply(1'b0, 4'b0000, d);
    check("held_ack_drop", 64'(asynchronous_data_ack[2]), 64'd0);

    // Reset while channel 3 sits in WAIT_DROP with valid still high.
    d = 32'h3C000000;
    for (int i = 0; i < 4; i++) apply(1'b0, 4'b1000, d);
    check("rst_pre_ack", 64'(asynchronous_data_ack[3]), 64'd1);
    apply(1'b1, 4'b1000, d);
    check("rst_ack_clear",  64'(asynchronous_data_ack),  64'd0);
    check("rst_data_clear", 64'(synchronous_data),       64'd0);
    check("rst_qpg_clear",  64'(Q_pulse_generator),      64'd0);
    idx = -1;
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 4'b1000, d);
      if (synchronous_data_valid[3] && idx < 0) idx = i + 1;
    end
    check("rst_restrobe_edges", 64'(idx), 64'(STAGE_COUNT + 1));
    check("rst_restrobe_data", 64'(synchronous_data[31:24]), 64'h3C);
    for (int i = 0; i < 4; i++) apply(1'b0, 4'b0000, d);

`ifdef DATA_SYNCHRONIZER_PROTOCOL_CHECK_EN
    apply(1'b1, 4'b0000, '0);
    check("perr_reset", 64'(protocol_error), 64'd0);
    for (int i = 0; i < 4; i++) apply(1'b0, 4'b0001, 32'h0000005A);
    check("perr_stable", 64'(protocol_error), 64'd0);
    for (int i = 0; i < 2; i++) apply(1'b0, 4'b0001, 32'h0000005B);
    check("perr_set", 64'(protocol_error), 64'd1);
    for (int i = 0; i < 5; i++) apply(1'b0, 4'b0000, 32'h0000005B);
    check("perr_sticky", 64'(protocol_error), 64'd1);
    apply(1'b1, 4'b0000, '0);
    check("perr_cleared", 64'(protocol_error), 64'd0);
`endif

    // Random traffic, including single-cycle glitches and occasional resets.
    v = '0;
    apply(1'b1, '0, '0);
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CHANNEL_COUNT; c++)
        if ($urandom_range(5) == 0) v[c] = ~v[c];
      apply(($urandom_range(299) == 0), v, DW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
